puf_eval_controller: RTL and testbench

//  Sequencing controller between the SIRC host handler and the PUF fabric (input/interconnect/output

---
 rtl/puf_eval_controller.sv | 139 +++++++++++++
 tb/tb_puf_eval_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_controller.sv
`default_nettype none
// ============================================================================
// Module   : puf_eval_controller
// Purpose  : Sequences repeated PUF evaluations, majority-votes each response
//            bit and reports voted response, XOR reduction and stability.
// Revision : 1.0 - initial release
// ============================================================================
module puf_eval_controller #(
    parameter int CHALLENGE_WIDTH  = 64,
    parameter int PDL_CONFIG_WIDTH = 64,
    parameter int RESPONSE_WIDTH   = 6,
    parameter int SETTLE_CYCLES    = 15,
    parameter int NUM_EVALS        = 5
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        trigger,
    input  logic [CHALLENGE_WIDTH-1:0]                  challenge,
    input  logic [PDL_CONFIG_WIDTH-1:0]                 pdl_config,
    output logic                                        busy,
    output logic                                        done,
    output logic [RESPONSE_WIDTH-1:0]                   raw_response,
    output logic                                        xor_response,
    output logic                                        stable,
    output logic [CHALLENGE_WIDTH+PDL_CONFIG_WIDTH-1:0] puf_challenge,
    output logic                                        puf_reset,
    output logic                                        puf_trigger,
    input  logic [RESPONSE_WIDTH-1:0]                   puf_response
);

    localparam int                c_vote_w      = $clog2(NUM_EVALS + 1);
    localparam logic [c_vote_w-1:0] c_num_evals = c_vote_w'(NUM_EVALS);
    localparam logic [c_vote_w-1:0] c_half      = c_vote_w'(NUM_EVALS / 2);
    localparam logic [7:0]        c_settle_last = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_FIRE   = 3'd2,
        S_SAMPLE = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [7:0]                r_settle_cnt;
    logic [c_vote_w-1:0]       r_eval_idx;
    logic [c_vote_w-1:0]       r_vote_cnt [RESPONSE_WIDTH];
    logic [RESPONSE_WIDTH-1:0] w_voted;
    logic [RESPONSE_WIDTH-1:0] w_bit_stable;
    logic                      w_settle_last;
    logic                      w_last_eval;

    assign w_settle_last = (r_settle_cnt == c_settle_last);
    assign w_last_eval   = ((r_eval_idx + c_vote_w'(1)) == c_num_evals);

    // A bit is stable when every evaluation agreed: all zeros or all ones.
    for (genvar gi = 0; gi < RESPONSE_WIDTH; gi++) begin : g_vote
        assign w_voted[gi]      = (r_vote_cnt[gi] > c_half);
        assign w_bit_stable[gi] = (r_vote_cnt[gi] == '0) || (r_vote_cnt[gi] == c_num_evals);
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        puf_reset    = 1'b0;
        puf_trigger  = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy      = 1'b0;
                puf_reset = 1'b1;
                if (trigger) w_state_next = S_ARM;
            end
            S_ARM: begin
                puf_reset    = 1'b1;
                w_state_next = S_FIRE;
            end
            S_FIRE: begin
                puf_trigger = 1'b1;
                if (w_settle_last) w_state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                puf_trigger  = 1'b1;
                w_state_next = w_last_eval ? S_FINISH : S_ARM;
            end
            S_FINISH: begin
                puf_reset    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                busy         = 1'b0;
                puf_reset    = 1'b1;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_settle_cnt  <= '0;
            r_eval_idx    <= '0;
            done          <= 1'b0;
            raw_response  <= '0;
            xor_response  <= 1'b0;
            stable        <= 1'b0;
            puf_challenge <= '0;
            for (int i = 0; i < RESPONSE_WIDTH; i++) r_vote_cnt[i] <= '0;
        end else begin
            r_state <= w_state_next;
            done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (trigger) begin
                        puf_challenge <= {challenge, pdl_config};
                        r_eval_idx    <= '0;
                        for (int i = 0; i < RESPONSE_WIDTH; i++) r_vote_cnt[i] <= '0;
                    end
                end
                S_ARM:  r_settle_cnt <= '0;
                S_FIRE: r_settle_cnt <= r_settle_cnt + 8'd1;
                S_SAMPLE: begin
                    r_eval_idx <= r_eval_idx + c_vote_w'(1);
                    for (int i = 0; i < RESPONSE_WIDTH; i++)
                        r_vote_cnt[i] <= r_vote_cnt[i] + c_vote_w'(puf_response[i]);
                end
                S_FINISH: begin
                    raw_response <= w_voted;
                    xor_response <= ^w_voted;
                    stable       <= &w_bit_stable;
                    done         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_puf_eval_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_puf_eval_controller
// Purpose  : Self-checking bench: vector table, PUF response model, scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_puf_eval_controller;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         trigger = 1'b0;
    logic [63:0]  challenge = '0;
    logic [63:0]  pdl_config = '0;
    logic         busy, done, xor_response, stable, puf_reset, puf_trigger;
    logic [5:0]   raw_response;
    logic [127:0] puf_challenge;
    logic [5:0]   puf_response = '0;

    logic         trigger_s = 1'b0;
    logic [5:0]   puf_response_s = '0;
    logic         busy_s, done_s, xor_s, stable_s, puf_reset_s, puf_trigger_s;
    logic [5:0]   raw_s;
    logic [127:0] puf_challenge_s;

    puf_eval_controller u_dut (
        .clk(clk), .reset(reset), .trigger(trigger), .challenge(challenge),
        .pdl_config(pdl_config), .busy(busy), .done(done), .raw_response(raw_response),
        .xor_response(xor_response), .stable(stable), .puf_challenge(puf_challenge),
        .puf_reset(puf_reset), .puf_trigger(puf_trigger), .puf_response(puf_response)
    );

    puf_eval_controller #(.SETTLE_CYCLES(1), .NUM_EVALS(1)) u_small (
        .clk(clk), .reset(reset), .trigger(trigger_s), .challenge(challenge),
        .pdl_config(pdl_config), .busy(busy_s), .done(done_s), .raw_response(raw_s),
        .xor_response(xor_s), .stable(stable_s), .puf_challenge(puf_challenge_s),
        .puf_reset(puf_reset_s), .puf_trigger(puf_trigger_s), .puf_response(puf_response_s)
    );

    typedef struct {
        logic [4:0][5:0] resp;
        logic [5:0]      raw;
        logic            xr;
        logic            st;
    } vec_t;

    typedef struct {
        logic [5:0]   raw;
        logic         xr;
        logic         st;
        logic [127:0] ch;
    } exp_t;

    vec_t          vecs [7];
    exp_t          sb [$];
    logic [4:0][5:0] cur_pat = '0;
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            trig_cyc = 0;
    int            eval_k = 0;
    logic          trig_prev = 1'b0;

    // PUF fabric model: a new pattern is presented on each launch.
    always @(negedge clk) begin
        if (!busy) eval_k = 0;
        else if (puf_trigger && !trig_prev) begin
            if (eval_k < 5) puf_response = cur_pat[eval_k];
            eval_k = eval_k + 1;
        end
        trig_prev = puf_trigger;
    end

    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
        if (puf_trigger) trig_cyc = trig_cyc + 1;
    end

    function automatic logic [4:0][5:0] mk(input logic [5:0] p0, p1, p2, p3, p4);
        return {p4, p3, p2, p1, p0};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int v, input logic [63:0] ch, input logic [63:0] pd,
                           input bit busy_trig);
        int   d0, t0, lat;
        exp_t e;
        cur_pat    = vecs[v].resp;
        challenge  = ch;
        pdl_config = pd;
        d0 = done_cnt;
        t0 = trig_cyc;
        lat = 0;
        @(negedge clk);
        trigger = 1'b1;
        e.raw = vecs[v].raw; e.xr = vecs[v].xr; e.st = vecs[v].st; e.ch = {ch, pd};
        sb.push_back(e);
        @(posedge clk); #1;
        trigger = 1'b0;
        chk($sformatf("v%0d_busy_start", v), 128'(busy), 128'(1));
        chk($sformatf("v%0d_challenge_latch", v), puf_challenge, {ch, pd});
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (busy_trig && i == 20) begin
                trigger = 1'b1; challenge = ~ch; pdl_config = ~pd;
            end
            if (busy_trig && i == 21) begin
                trigger = 1'b0;
                chk("busy_trig_challenge_held", puf_challenge, {ch, pd});
            end
            if (done) begin lat = i; break; end
        end
        chk($sformatf("v%0d_latency", v), 128'(lat), 128'(86));
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL v%0d_scoreboard_empty actual=0 expected=1", v);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_raw", v), 128'(raw_response), 128'(e.raw));
            chk($sformatf("v%0d_xor", v), 128'(xor_response), 128'(e.xr));
            chk($sformatf("v%0d_stable", v), 128'(stable), 128'(e.st));
            chk($sformatf("v%0d_challenge_end", v), puf_challenge, e.ch);
        end
        repeat (busy_trig ? 100 : 3) @(posedge clk);
        #1;
        chk($sformatf("v%0d_done_pulses", v), 128'(done_cnt - d0), 128'(1));
        chk($sformatf("v%0d_trigger_cycles", v), 128'(trig_cyc - t0), 128'(80));
        chk($sformatf("v%0d_busy_end", v), 128'(busy), 128'(0));
    endtask

    task automatic run_small(input logic [5:0] resp, input logic [5:0] exp_raw, input logic exp_xr);
        int lat;
        lat = 0;
        puf_response_s = resp;
        @(negedge clk);
        trigger_s = 1'b1;
        @(posedge clk); #1;
        trigger_s = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (done_s) begin lat = i; break; end
        end
        chk("small_latency", 128'(lat), 128'(4));
        chk("small_raw", 128'(raw_s), 128'(exp_raw));
        chk("small_xor", 128'(xor_s), 128'(exp_xr));
        chk("small_stable", 128'(stable_s), 128'(1));
    endtask

    initial begin
        int d0;
        vecs[0] = '{mk(6'b101101, 6'b101101, 6'b101101, 6'b101101, 6'b101101), 6'b101101, 1'b0, 1'b1};
        vecs[1] = '{mk(6'b000011, 6'b000001, 6'b000011, 6'b100001, 6'b000011), 6'b000011, 1'b0, 1'b0};
        vecs[2] = '{mk(6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000), 6'b000000, 1'b0, 1'b1};
        vecs[3] = '{mk(6'b111000, 6'b111000, 6'b000111, 6'b000111, 6'b111111), 6'b111111, 1'b0, 1'b0};
        vecs[4] = '{mk(6'b100000, 6'b100000, 6'b000000, 6'b000000, 6'b000001), 6'b000000, 1'b0, 1'b0};
        vecs[5] = '{mk(6'b010000, 6'b010000, 6'b010000, 6'b010000, 6'b010000), 6'b010000, 1'b1, 1'b1};
        vecs[6] = '{mk(6'b110101, 6'b110100, 6'b010101, 6'b110101, 6'b000001), 6'b110101, 1'b0, 1'b0};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_raw", 128'(raw_response), 128'(0));
        chk("rst_xor", 128'(xor_response), 128'(0));
        chk("rst_stable", 128'(stable), 128'(0));
        chk("rst_challenge", puf_challenge, 128'(0));
        chk("rst_puf_trigger", 128'(puf_trigger), 128'(0));
        chk("rst_puf_reset", 128'(puf_reset), 128'(1));
        reset = 1'b0;

        for (int v = 0; v < 7; v++)
            run_vec(v, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);

        run_vec(0, 64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98, 1'b1);

        // Mid-run reset: the aborted run must never report.
        cur_pat = vecs[5].resp;
        d0 = done_cnt;
        @(negedge clk);
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_done", 128'(done), 128'(0));
        chk("midrst_puf_reset", 128'(puf_reset), 128'(1));
        chk("midrst_puf_trigger", 128'(puf_trigger), 128'(0));
        chk("midrst_raw", 128'(raw_response), 128'(0));
        chk("midrst_challenge", puf_challenge, 128'(0));
        repeat (100) @(posedge clk);
        #1;
        chk("midrst_no_done", 128'(done_cnt - d0), 128'(0));
        run_vec(1, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0);

        run_small(6'b111111, 6'b111111, 1'b0);
        run_small(6'b101100, 6'b101100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
